dca_step_sequencer: RTL
=======================

DCA_STEP_SEQUENCER -- requirements
Module: dca_step_sequencer

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, the max issued-but-uncompleted steps (1..15).
REQ-002 SHALL have parameter BW_NUM_K, default 8, the width of the step-count field.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstnn, input, 1, the reset, which is synchronous and active-low.
REQ-005 SHALL have port clear, input, 1, a synchronous abort to IDLE.
REQ-006 SHALL have port start, input, 1, a pulse that latches the cfg_* inputs and begins a job.
REQ-007 SHALL have port cfg_num_k, input, BW_NUM_K, the number of MAC steps.
REQ-008 SHALL have port cfg_load_acc, input, 1, which selects loading the accumulator on the first MAC step.
REQ-009 SHALL have port cfg_store, input, 1, which appends one store step after the MAC steps.
REQ-010 SHALL have ports inst_valid (output, 1), inst_ready (input, 1) and inst (output, 6): the step-instruction handshake to the step unit.
REQ-011 SHALL have port step_done, input, 1, a one-cycle completion pulse per issued step.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, sticky).
REQ-013 SHALL have port stall_cnt, output, 16, the cycles in which inst_valid is high and inst_ready is low.

Function
REQ-014 SHALL use the inst encoding {last, opcode[4:0]}; opcode bits are 0 NO_CAL, 1 LSU0_REQ, 2 LSU1_REQ, 3 LSU2_REQ, 4 LOAD_ACC.
REQ-015 SHALL issue MAC step k (k=0..num_k-1) with opcode LSU0_REQ|LSU1_REQ.
- Step k=0 additionally sets LOAD_ACC|LSU2_REQ when load_acc=1.
REQ-016 SHALL issue the store step, when store=1, with opcode NO_CAL|LSU2_REQ.
REQ-017 SHALL set last=1 only on the final issued step of a job.
REQ-018 SHALL implement the states IDLE, ISSUE and DRAIN.
- IDLE->ISSUE on start when the total step count is nonzero.
- ISSUE->DRAIN on the handshake of the last step.
- DRAIN->IDLE when outstanding==0, with a done pulse in the same cycle.
REQ-019 SHALL pulse done in the cycle after start, and remain in IDLE, when num_k=0 and store=0.
REQ-020 SHALL use num_k=0 with store=1 to issue only the store step, with last=1.
REQ-021 SHALL assert inst_valid only in ISSUE and only while outstanding<MAX_OUTSTANDING.
- Once asserted, inst_valid and inst SHALL hold stable until inst_ready.
REQ-022 SHALL count a step as issued on the cycle inst_valid&inst_ready.
- outstanding SHALL increment on issue and decrement on step_done.
- Simultaneous issue and step_done SHALL leave outstanding unchanged.
REQ-023 SHALL treat step_done with outstanding==0 as follows: ignore it for the count and set err.
REQ-024 SHALL clear err on start.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL drive busy=1 in ISSUE and DRAIN.
REQ-027 SHALL respond to clear by moving to IDLE next cycle, zeroing outstanding and the step index, deasserting inst_valid, and producing no done pulse.
- clear SHALL take priority over start in the same cycle.
REQ-028 SHALL pass start-cycle cfg values only; later cfg changes SHALL have no effect mid-job.

Reset
REQ-029 SHALL, on rstnn=0 at a clock edge, set state=IDLE, outstanding=0, step index=0, latched cfg=0, inst_valid=0, inst=0, busy=0, done=0, err=0 and stall_cnt=0.
REQ-030 SHALL abort any in-flight job on a reset applied mid-job, with no done pulse.

Configuration
REQ-031 SHALL implement the stall counter under macro DCA_STEP_SEQUENCER_STALL_CNT_EN.
- When defined: stall_cnt increments on each inst_valid&~inst_ready cycle, saturates at 0xFFFF, and clears on start, clear and reset.
- When undefined: stall_cnt is constant 0 and no counter logic exists.

Verification
REQ-032 SHALL cover num_k=3, load_acc=1, store=1, with inst_ready=1 and step_done 2 cycles after each issue.
- inst sequence: 0x1E, 0x06, 0x06, 0x29.
- One done pulse after the 4th step_done.
REQ-033 SHALL cover num_k=6, MAX_OUTSTANDING=4, with step_done withheld.
- Exactly 4 issues, then inst_valid=0.
- One step_done -> exactly one more issue.
REQ-034 SHALL cover num_k=0, store=0 -> done=1 in the next cycle, busy stays 0, and no inst_valid.
REQ-035 SHALL cover num_k=2, with inst_ready=0 for 5 cycles and then 1.
- inst is held stable throughout the stall.
- stall_cnt=5 with the macro defined, 0 without it.
REQ-036 SHALL cover clear asserted in ISSUE after the 1st issue -> IDLE next cycle, outstanding=0, and no done pulse.
- A later step_done then sets err=1.

Source files
------------

// File: rtl/dca_step_sequencer_if.sv
// Step-instruction channel between the sequencer (master) and the step unit (slave).
interface dca_step_sequencer_if;
    logic       inst_valid;
    logic       inst_ready;
    logic [5:0] inst;
    logic       step_done;

    modport master (
        output inst_valid,
        output inst,
        input  inst_ready,
        input  step_done
    );

    modport slave (
        input  inst_valid,
        input  inst,
        output inst_ready,
        output step_done
    );
endinterface

// File: rtl/dca_step_sequencer.sv
// Issues a job of MAC steps plus an optional store step, bounding issued-but-uncompleted steps.
// Define DCA_STEP_SEQUENCER_STALL_CNT_EN to build the saturating stall counter.
module dca_step_sequencer #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BW_NUM_K        = 8
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    clear,
    input  logic                    start,
    input  logic [BW_NUM_K-1:0]     cfg_num_k,
    input  logic                    cfg_load_acc,
    input  logic                    cfg_store,
    dca_step_sequencer_if.master    step_if,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             stall_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    localparam int         IW    = BW_NUM_K + 1;
    localparam logic [3:0] MAX_Q = 4'(MAX_OUTSTANDING);

    state_e              state_q, state_d;
    logic [3:0]          out_q, out_d, out_nx;
    logic [IW-1:0]       idx_q, idx_d, total_q;
    logic [BW_NUM_K-1:0] num_k_q, num_k_d;
    logic                load_acc_q, load_acc_d;
    logic                store_q, store_d;
    logic                inst_valid_q, inst_valid_d;
    logic [5:0]          inst_q, inst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                fire, spurious;

    // Step idx of a job: MAC steps first, then the optional store; bit 5 marks the final step.
    function automatic logic [5:0] encode(input logic [IW-1:0]       idx,
                                          input logic [BW_NUM_K-1:0] nk,
                                          input logic                la,
                                          input logic                st);
        logic [IW-1:0] total;
        logic [4:0]    op;
        total = {1'b0, nk} + IW'(st);
        if (idx < {1'b0, nk}) begin
            op = 5'b00110;
            if (idx == '0 && la) op = op | 5'b11000;
        end else begin
            op = 5'b01001;
        end
        return {idx == total - IW'(1), op};
    endfunction

    assign fire     = inst_valid_q & step_if.inst_ready;
    assign spurious = step_if.step_done & (out_q == 4'd0);
    assign total_q  = {1'b0, num_k_q} + IW'(store_q);
    assign out_nx   = out_q + 4'(fire) - 4'(step_if.step_done & ~spurious);

    always_comb begin
        state_d      = state_q;
        out_d        = out_nx;
        idx_d        = idx_q;
        num_k_d      = num_k_q;
        load_acc_d   = load_acc_q;
        store_d      = store_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        done_d       = 1'b0;
        err_d        = err_q | spurious;
        if (clear) begin
            state_d      = IDLE;
            out_d        = '0;
            idx_d        = '0;
            inst_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_k_d    = cfg_num_k;
                        load_acc_d = cfg_load_acc;
                        store_d    = cfg_store;
                        idx_d      = '0;
                        err_d      = spurious;
                        if (cfg_num_k == '0 && !cfg_store) begin
                            done_d = 1'b1;
                        end else begin
                            state_d      = ISSUE;
                            inst_valid_d = 1'b1;
                            inst_d       = encode('0, cfg_num_k, cfg_load_acc, cfg_store);
                        end
                    end
                end
                ISSUE: begin
                    idx_d = idx_q + IW'(fire);
                    if (fire && idx_q == total_q - IW'(1)) begin
                        state_d      = DRAIN;
                        inst_valid_d = 1'b0;
                    end else if (!inst_valid_q || fire) begin
                        // A presented step is never withdrawn; only re-evaluate once it is taken.
                        inst_valid_d = (out_nx < MAX_Q);
                        inst_d       = encode(idx_d, num_k_q, load_acc_q, store_q);
                    end
                end
                DRAIN: begin
                    if (out_nx == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state_q      <= IDLE;
            out_q        <= '0;
            idx_q        <= '0;
            num_k_q      <= '0;
            load_acc_q   <= 1'b0;
            store_q      <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            idx_q        <= idx_d;
            num_k_q      <= num_k_d;
            load_acc_q   <= load_acc_d;
            store_q      <= store_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef DCA_STEP_SEQUENCER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (inst_valid_q && !step_if.inst_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        if (clear || (state_q == IDLE && start)) stall_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rstnn) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign step_if.inst_valid = inst_valid_q;
    assign step_if.inst       = inst_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;

endmodule
